// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter: ownership state, requester id and the RAM request word.
package ram_arb_pkg;

  localparam int RAM_ADDR_W = 16;
  localparam int RAM_DATA_W = 16;

  typedef enum logic {
    OWN_FREE   = 1'b0,
    OWN_A_LOCK = 1'b1
  } owner_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_e;

  // The top's ADDR_W/DATA_W must equal these widths.
  typedef struct packed {
    logic                  we;
    logic [RAM_ADDR_W-1:0] addr;
    logic [RAM_DATA_W-1:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/ram_arb_rd_pipe.sv
// Read-return tracker: a valid/owner shift register whose last stage lines up with q_ram.
module ram_arb_rd_pipe
  import ram_arb_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic     clock_i,
  input  logic     reset_i,
  input  logic     push_i,
  input  port_id_e id_i,
  output logic     a_rvalid_o,
  output logic     b_rvalid_o
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] id_b_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid_q <= '0;
      id_b_q  <= '0;
    end else begin
      valid_q <= {valid_q[DEPTH-2:0], push_i};
      id_b_q  <= {id_b_q[DEPTH-2:0], (id_i == PORT_B)};
    end
  end

  assign a_rvalid_o = valid_q[DEPTH-1] && !id_b_q[DEPTH-1];
  assign b_rvalid_o = valid_q[DEPTH-1] &&  id_b_q[DEPTH-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between the CPU (port A, priority + lock) and the I/O/debug engine
// (port B, starvation-protected); registers the winner onto the RAM and routes read data back.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W      = RAM_ADDR_W,
  parameter int DATA_W      = RAM_DATA_W,
  parameter int RAM_LATENCY = 2,
  parameter int MAX_WAIT    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              a_lock,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] address_ram,
  output logic              wren_ram,
  output logic [DATA_W-1:0] data_ram,
  input  logic [DATA_W-1:0] q_ram
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  ram_req_t          req_q, req_d;
  logic              a_gnt_c, b_gnt_c;
  logic              starve_at_max;
  logic              rd_push;
  port_id_e          rd_id;

  assign starve_at_max = (starve_q == CNT_W'(MAX_WAIT));

  always_comb begin
    owner_d  = owner_q;
    starve_d = starve_q;
    a_gnt_c  = 1'b0;
    b_gnt_c  = 1'b0;
    req_d    = req_q;
    req_d.we = 1'b0;

    if (owner_q == OWN_A_LOCK) begin
      a_gnt_c = a_req;
      if (!a_lock) owner_d = OWN_FREE;
    end else begin
      b_gnt_c = b_req && (!a_req || starve_at_max);
      a_gnt_c = a_req && !b_gnt_c;
      if (a_gnt_c && a_lock) owner_d = OWN_A_LOCK;
    end

    // Counts consecutive denied B cycles; any idle or granted B cycle restarts the count.
    if (!b_req || b_gnt_c) begin
      starve_d = '0;
    end else if (!starve_at_max) begin
      starve_d = starve_q + 1'b1;
    end

    if (a_gnt_c) begin
      req_d = '{we: a_we, addr: a_addr, wdata: a_wdata};
    end else if (b_gnt_c) begin
      req_d = '{we: b_we, addr: b_addr, wdata: b_wdata};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q  <= OWN_FREE;
      starve_q <= '0;
      req_q    <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
      req_q    <= req_d;
    end
  end

  assign rd_push = (a_gnt_c && !a_we) || (b_gnt_c && !b_we);
  assign rd_id   = b_gnt_c ? PORT_B : PORT_A;

  // One stage for the address register plus RAM_LATENCY stages inside the RAM.
  ram_arb_rd_pipe #(
    .DEPTH(RAM_LATENCY + 1)
  ) u_rd_pipe (
    .clock_i   (clock),
    .reset_i   (reset),
    .push_i    (rd_push),
    .id_i      (rd_id),
    .a_rvalid_o(a_rvalid),
    .b_rvalid_o(b_rvalid)
  );

  assign a_gnt       = a_gnt_c;
  assign b_gnt       = b_gnt_c;
  assign a_rdata     = q_ram;
  assign b_rdata     = q_ram;
  assign address_ram = req_q.addr;
  assign wren_ram    = req_q.we;
  assign data_ram    = req_q.wdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios then random traffic against a
// transaction-level model (shadow memory + return queue) and a registered-address/registered-q RAM.
module tb_ram_port_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 2;
  localparam int MW  = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          a_req, a_we, a_lock;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt, a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          b_req, b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt, b_rvalid;
  logic [DW-1:0] b_rdata;
  logic [AW-1:0] address_ram;
  logic          wren_ram;
  logic [DW-1:0] data_ram;
  logic [DW-1:0] q_ram;

  always #5 clock = ~clock;

  ram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RAM_LATENCY(LAT), .MAX_WAIT(MW)
  ) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .address_ram(address_ram), .wren_ram(wren_ram), .data_ram(data_ram), .q_ram(q_ram)
  );

  function automatic logic [15:0] seed_val(int i);
    return 16'(i * 40503 + 4660);
  endfunction

  // RAM with registered address and registered q (two edges from address_ram to q_ram).
  logic [DW-1:0] ram_mem [256];
  logic [AW-1:0] ram_addr_q;
  bit            ram_ready;

  always @(posedge clock) begin
    if (!ram_ready) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= seed_val(i);
      ram_ready <= 1'b1;
    end else if (wren_ram === 1'b1) begin
      ram_mem[address_ram[7:0]] <= data_ram;
    end
    ram_addr_q <= address_ram;
    q_ram      <= ram_mem[ram_addr_q[7:0]];
  end

  // Reference model state
  typedef struct {
    int            due;
    bit            port_b;
    logic [15:0]   data;
  } ret_t;

  logic [15:0] shadow [256];
  ret_t        ret_q[$];
  bit          locked;
  int          waited;
  int          cyc;
  logic [15:0] exp_addr, exp_data;
  logic        exp_wren;
  int          passed, fails, total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_a(input bit req, input bit we, input logic [15:0] ad,
                       input logic [15:0] wd, input bit lk);
    a_req = req; a_we = we; a_addr = ad; a_wdata = wd; a_lock = lk;
  endtask

  task automatic set_b(input bit req, input bit we, input logic [15:0] ad, input logic [15:0] wd);
    b_req = req; b_we = we; b_addr = ad; b_wdata = wd;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    set_b(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // One clock cycle: check combinational grants and read returns mid-cycle, advance the model,
  // then check the registered RAM port just after the edge.
  task automatic step();
    bit          ea, eb, av, bv, we;
    logic [15:0] rd, ad, wd;
    @(negedge clock);
    eb = b_req && !locked && (!a_req || waited >= MW);
    ea = a_req && !eb;
    chk("a_gnt", {31'b0, a_gnt}, {31'b0, ea});
    chk("b_gnt", {31'b0, b_gnt}, {31'b0, eb});
    av = 1'b0; bv = 1'b0; rd = '0;
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      av = !ret_q[0].port_b;
      bv = ret_q[0].port_b;
      rd = ret_q[0].data;
      void'(ret_q.pop_front());
    end
    chk("a_rvalid", {31'b0, a_rvalid}, {31'b0, av});
    chk("b_rvalid", {31'b0, b_rvalid}, {31'b0, bv});
    if (av) chk("a_rdata", {16'b0, a_rdata}, {16'b0, rd});
    if (bv) chk("b_rdata", {16'b0, b_rdata}, {16'b0, rd});

    if (reset) begin
      locked = 1'b0; waited = 0; ret_q.delete();
      exp_addr = '0; exp_data = '0; exp_wren = 1'b0;
    end else begin
      exp_wren = 1'b0;
      if (ea || eb) begin
        we = ea ? a_we : b_we;
        ad = ea ? a_addr : b_addr;
        wd = ea ? a_wdata : b_wdata;
        exp_addr = ad; exp_data = wd; exp_wren = we;
        if (we) shadow[ad[7:0]] = wd;
        else ret_q.push_back('{cyc + LAT + 1, eb, shadow[ad[7:0]]});
      end
      if (!b_req || eb) waited = 0;
      else if (waited < MW) waited++;
      if (locked && !a_lock) locked = 1'b0;
      else if (!locked && ea && a_lock) locked = 1'b1;
    end

    @(posedge clock);
    #1;
    cyc++;
    chk("address_ram", {16'b0, address_ram}, {16'b0, exp_addr});
    chk("wren_ram", {31'b0, wren_ram}, {31'b0, exp_wren});
    chk("data_ram", {16'b0, data_ram}, {16'b0, exp_data});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = seed_val(i);
    passed = 0; fails = 0; total = 0; cyc = 0;
    locked = 1'b0; waited = 0;
    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();

    // Single A read
    set_a(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0); step();
    idle(); repeat (4) step();

    // Single B write, then read it back through A
    set_b(1'b1, 1'b1, 16'h0001, 16'h00AB); step();
    idle(); repeat (3) step();
    set_a(1'b1, 1'b0, 16'h0001, 16'h0, 1'b0); step();
    idle(); repeat (4) step();

    // Contention: both ports request continuously
    for (int k = 0; k < 12; k++) begin
      set_a(1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom), 1'b0);
      set_b(1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom));
      step();
    end
    idle(); repeat (4) step();

    // A lock across three requests while B keeps asking
    for (int k = 0; k < 3; k++) begin
      set_a(1'b1, 1'b0, 16'($urandom_range(0, 31)), 16'h0, 1'b1);
      set_b(1'b1, 1'b0, 16'h0040, 16'h0);
      step();
    end
    set_a(1'b0, 1'b0, 16'h0, 16'h0, 1'b1); repeat (3) step();
    set_a(1'b0, 1'b0, 16'h0, 16'h0, 1'b0); step();
    set_a(1'b1, 1'b0, 16'h0041, 16'h0, 1'b0); step();
    step();
    idle(); repeat (4) step();

    // Interleaved reads A, B, A and a read-after-write
    set_a(1'b1, 1'b0, 16'h0002, 16'h0, 1'b0); step();
    idle(); set_b(1'b1, 1'b0, 16'h0003, 16'h0); step();
    idle(); set_a(1'b1, 1'b0, 16'h0004, 16'h0, 1'b0); step();
    set_a(1'b1, 1'b1, 16'h0020, 16'hBEEF, 1'b0); step();
    set_a(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0); step();
    idle(); repeat (4) step();

    // Reset right after an accepted read discards it
    set_a(1'b1, 1'b0, 16'h0005, 16'h0, 1'b1); step();
    idle(); reset = 1'b1; step();
    reset = 1'b0; repeat (4) step();
    set_a(1'b1, 1'b0, 16'h0006, 16'h0, 1'b0); set_b(1'b1, 1'b0, 16'h0007, 16'h0); step();
    idle(); repeat (4) step();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)),
            16'($urandom), ($urandom_range(0, 3) == 0));
      set_b(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)),
            16'($urandom));
      step();
    end
    idle(); repeat (5) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
